// File: rtl/muldiv_seq_pkg.sv
// Shared aluop encodings, sequencer states and handshake levels for muldiv_seq.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_seq_pkg;

  // aluop encodings handled by the sequencer
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [7:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b10101011;

  // divider handshake and stall levels
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic Stop           = 1'b1;
  localparam logic NoStop         = 1'b0;

  typedef enum logic [1:0] {
    MDS_IDLE     = 2'd0,
    MDS_ACC      = 2'd1,
    MDS_DIV_WAIT = 2'd2,
    MDS_DIV_END  = 2'd3
  } mds_state_t;

  function automatic logic is_acc_op(input logic [7:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

  function automatic logic is_sub_op(input logic [7:0] op);
    return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// EX-stage sequencer for MADD/MSUB accumulate and the iterative divider handshake.
// Latency: accumulate 2 cycles; divide 1 start + divider cycles + 1 end (div-by-zero 2 cycles).
// Backpressure: stalls EX until the HI/LO write is ready; hold_i freezes the final state, flush_i aborts.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [63:0] mulres_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o
);

  mds_state_t  state;
  logic [63:0] acc_reg;
  logic [63:0] res_reg;
  logic [31:0] op1_reg;
  logic [31:0] op2_reg;
  logic        signed_reg;
  logic [63:0] acc_sum;

  // carry out of bit 63 is intentionally dropped: accumulate wraps mod 2^64
  assign acc_sum = {hi_i, lo_i} + acc_reg;

  // state transitions and operand/result capture; flush overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MDS_IDLE;
      acc_reg    <= 64'd0;
      res_reg    <= 64'd0;
      op1_reg    <= 32'd0;
      op2_reg    <= 32'd0;
      signed_reg <= 1'b0;
    end else if (flush_i) begin
      state <= MDS_IDLE;
    end else begin
      case (state)
        MDS_IDLE: begin
          if (is_acc_op(aluop_i)) begin
            acc_reg <= is_sub_op(aluop_i) ? (~mulres_i + 64'd1) : mulres_i;
            state   <= MDS_ACC;
          end else if (is_div_op(aluop_i)) begin
            if (reg2_i != 32'd0) begin
              op1_reg    <= reg1_i;
              op2_reg    <= reg2_i;
              signed_reg <= (aluop_i == EXE_DIV_OP);
              state      <= MDS_DIV_WAIT;
            end else begin
              // divide by zero never reaches the divider
              res_reg <= {reg1_i, DIV_ZERO_LO};
              state   <= MDS_DIV_END;
            end
          end
        end
        MDS_ACC: begin
          if (!hold_i) state <= MDS_IDLE;
        end
        MDS_DIV_WAIT: begin
          if (div_ready_i == DivResultReady) begin
            res_reg <= div_result_i;
            state   <= MDS_DIV_END;
          end
        end
        MDS_DIV_END: begin
          if (!hold_i) state <= MDS_IDLE;
        end
        default: state <= MDS_IDLE;
      endcase
    end
  end

  // outputs follow the current-cycle aluop in IDLE, so they are decoded combinationally
  always_comb begin
    div_start_o   = DivStop;
    div_annul_o   = 1'b0;
    div_signed_o  = 1'b0;
    div_opdata1_o = 32'd0;
    div_opdata2_o = 32'd0;
    stallreq_o    = NoStop;
    whilo_o       = 1'b0;
    hi_o          = 32'd0;
    lo_o          = 32'd0;
    busy_o        = 1'b0;
    if (!rst) begin
      busy_o = (state != MDS_IDLE);
      if (flush_i) begin
        // reset silently drops a divide; only a flush tells the divider to stop
        div_annul_o = (state == MDS_DIV_WAIT);
      end else begin
        case (state)
          MDS_IDLE: begin
            if (is_acc_op(aluop_i)) begin
              stallreq_o = Stop;
            end else if (is_div_op(aluop_i)) begin
              stallreq_o = Stop;
              if (reg2_i != 32'd0) begin
                div_start_o   = DivStart;
                div_opdata1_o = reg1_i;
                div_opdata2_o = reg2_i;
                div_signed_o  = (aluop_i == EXE_DIV_OP);
              end
            end
          end
          MDS_ACC: begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = acc_sum;
          end
          MDS_DIV_WAIT: begin
            div_start_o   = DivStart;
            div_opdata1_o = op1_reg;
            div_opdata2_o = op2_reg;
            div_signed_o  = signed_reg;
            stallreq_o    = Stop;
          end
          MDS_DIV_END: begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = res_reg;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized transactions.
// Latency: n/a.
// Backpressure: exercises hold_i, flush_i and reset during operations.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
  logic [63:0] mulres_i;
  logic        hold_i, flush_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic        stallreq_o, whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] NOP = 8'h00;

  muldiv_seq #(.DIV_ZERO_LO(32'hFFFFFFFF)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .hi_i(hi_i), .lo_i(lo_i), .mulres_i(mulres_i), .hold_i(hold_i), .flush_i(flush_i),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not end, got running, want finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // advance one clock and land 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    aluop_i = NOP; hold_i = 1'b0; flush_i = 1'b0;
    div_ready_i = 1'b0; div_result_i = 64'd0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".stall"}, {63'd0, stallreq_o}, 64'd0);
    check({tag, ".whilo"}, {63'd0, whilo_o}, 64'd0);
    check({tag, ".start"}, {63'd0, div_start_o}, 64'd0);
    check({tag, ".annul"}, {63'd0, div_annul_o}, 64'd0);
    check({tag, ".busy"}, {63'd0, busy_o}, 64'd0);
    check({tag, ".hilo"}, {hi_o, lo_o}, 64'd0);
    check({tag, ".opd"}, {div_opdata1_o, div_opdata2_o}, 64'd0);
    check({tag, ".sgn"}, {63'd0, div_signed_o}, 64'd0);
  endtask

  // reference model: accumulate result is {hi,lo} plus or minus the product, mod 2^64
  function automatic logic [63:0] acc_model(input logic [7:0] op, input logic [63:0] hilo,
                                            input logic [63:0] prod);
    if (op == EXE_MSUB_OP || op == EXE_MSUBU_OP) return hilo - prod;
    return hilo + prod;
  endfunction

  // reference divider: {remainder, quotient} with truncating division
  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] q, r;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic do_acc(input logic [7:0] op, input logic [31:0] hi, input logic [31:0] lo,
                        input logic [63:0] prod, input int nhold);
    logic [63:0] exp;
    exp = acc_model(op, {hi, lo}, prod);
    aluop_i = op; hi_i = hi; lo_i = lo; mulres_i = prod; hold_i = 1'b0;
    settle();
    check("acc.c1.stall", {63'd0, stallreq_o}, 64'd1);
    check("acc.c1.whilo", {63'd0, whilo_o}, 64'd0);
    check("acc.c1.start", {63'd0, div_start_o}, 64'd0);
    tick();
    for (int h = 0; h <= nhold; h++) begin
      hold_i = (h < nhold);
      settle();
      check("acc.c2.whilo", {63'd0, whilo_o}, 64'd1);
      check("acc.c2.stall", {63'd0, stallreq_o}, 64'd0);
      check("acc.c2.hilo", {hi_o, lo_o}, exp);
      check("acc.c2.busy", {63'd0, busy_o}, 64'd1);
      tick();
    end
    idle_inputs();
    settle();
    check("acc.done.busy", {63'd0, busy_o}, 64'd0);
  endtask

  // lat = cycles spent waiting in the divider before ready; flush_at < lat aborts there
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int flush_at, input int nhold);
    logic [63:0] exp;
    aluop_i = sgn ? EXE_DIV_OP : EXE_DIVU_OP; reg1_i = a; reg2_i = b; hold_i = 1'b0;
    settle();
    check("div.c1.stall", {63'd0, stallreq_o}, 64'd1);
    if (b == 32'd0) begin
      check("div0.c1.start", {63'd0, div_start_o}, 64'd0);
      exp = {a, 32'hFFFFFFFF};
    end else begin
      check("div.c1.start", {63'd0, div_start_o}, 64'd1);
      check("div.c1.opd", {div_opdata1_o, div_opdata2_o}, {a, b});
      check("div.c1.sgn", {63'd0, div_signed_o}, {63'd0, sgn});
      exp = div_model(sgn, a, b);
      tick();
      // operands on the EX inputs may change once captured
      reg1_i = $urandom; reg2_i = $urandom;
      for (int i = 0; i < lat; i++) begin
        if (i == flush_at) begin
          flush_i = 1'b1;
          div_ready_i = (i == lat - 1);
          div_result_i = exp;
          settle();
          check("div.flush.annul", {63'd0, div_annul_o}, 64'd1);
          check("div.flush.start", {63'd0, div_start_o}, 64'd0);
          check("div.flush.whilo", {63'd0, whilo_o}, 64'd0);
          check("div.flush.stall", {63'd0, stallreq_o}, 64'd0);
          tick();
          idle_inputs();
          settle();
          check("div.flush.busy", {63'd0, busy_o}, 64'd0);
          check("div.flush.annul_off", {63'd0, div_annul_o}, 64'd0);
          return;
        end
        div_ready_i = (i == lat - 1);
        div_result_i = div_ready_i ? exp : 64'($urandom);
        settle();
        check("div.wait.start", {63'd0, div_start_o}, 64'd1);
        check("div.wait.stall", {63'd0, stallreq_o}, 64'd1);
        check("div.wait.opd", {div_opdata1_o, div_opdata2_o}, {a, b});
        check("div.wait.sgn", {63'd0, div_signed_o}, {63'd0, sgn});
        check("div.wait.whilo", {63'd0, whilo_o}, 64'd0);
        tick();
      end
      div_ready_i = 1'b0;
      div_result_i = 64'd0;
    end
    if (b == 32'd0) tick();
    for (int h = 0; h <= nhold; h++) begin
      hold_i = (h < nhold);
      settle();
      check("div.end.whilo", {63'd0, whilo_o}, 64'd1);
      check("div.end.stall", {63'd0, stallreq_o}, 64'd0);
      check("div.end.start", {63'd0, div_start_o}, 64'd0);
      check("div.end.hilo", {hi_o, lo_o}, exp);
      tick();
    end
    idle_inputs();
    settle();
    check("div.done.busy", {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    idle_inputs();
    reg1_i = 0; reg2_i = 0; hi_i = 0; lo_i = 0; mulres_i = 0;
    rst = 1'b1;
    tick(); tick();
    check_quiet("reset");
    rst = 1'b0;
    settle();
    check_quiet("post_reset");

    // directed cases
    do_acc(EXE_MADD_OP, 32'd0, 32'd5, 64'd12, 0);
    do_acc(EXE_MSUB_OP, 32'd0, 32'd0, 64'd1, 3);
    do_acc(EXE_MADDU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd2, 0);   // carry out dropped
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 33, -1, 0);
    do_div(1'b0, 32'd9, 32'd0, 0, -1, 0);
    do_div(1'b0, 32'd100, 32'd0, 0, -1, 2);
    do_div(1'b1, 32'd1000, 32'd7, 10, 4, 0);                      // flush in DIV_WAIT
    do_acc(EXE_MADDU_OP, 32'd1, 32'd2, 64'h0000_0003_0000_0004, 0);
    do_div(1'b0, 32'd50, 32'd3, 6, 5, 0);                         // flush beats ready

    // flush in IDLE with an op present: not accepted
    aluop_i = EXE_MADD_OP; flush_i = 1'b1;
    settle();
    check("idle_flush.stall", {63'd0, stallreq_o}, 64'd0);
    tick();
    idle_inputs();
    settle();
    check("idle_flush.busy", {63'd0, busy_o}, 64'd0);

    // reset during DIV_WAIT: drop silently
    aluop_i = EXE_DIV_OP; reg1_i = 32'd77; reg2_i = 32'd5;
    tick(); tick();
    settle();
    check("rst_div.busy_before", {63'd0, busy_o}, 64'd1);
    rst = 1'b1;
    settle();
    check("rst_div.annul", {63'd0, div_annul_o}, 64'd0);
    tick();
    rst = 1'b0; aluop_i = NOP;
    settle();
    check_quiet("rst_div.after");

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 5);
      if (kind < 4) begin
        logic [7:0] op;
        case (kind)
          0: op = EXE_MADD_OP;
          1: op = EXE_MADDU_OP;
          2: op = EXE_MSUB_OP;
          default: op = EXE_MSUBU_OP;
        endcase
        do_acc(op, $urandom, $urandom, {$urandom, $urandom}, $urandom_range(0, 2));
      end else begin
        logic [31:0] b;
        int lat, fa;
        b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
        if (b == 32'hFFFFFFFF) b = 32'd3;
        lat = $urandom_range(1, 40);
        fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat - 1) : -1;
        do_div(kind == 4, $urandom, b, lat, fa, $urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for HI/LO-writing arithmetic in the EX stage.
- Owns the two-cycle MADD/MADDU/MSUB/MSUBU accumulate and the start/ready handshake with the shared iterative divider.
- Produces the EX stall request and the final HI/LO write (whilo/hi/lo) that EX forwards to ex_mem.
- Instantiated beside EX. Single-cycle ALU ops bypass it entirely.

Parameters:
- DIV_ZERO_LO, 32'hFFFFFFFF, LO value written when the divisor is zero (HI gets the dividend).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- aluop_i  in  8  EX-stage aluop; held stable while stallreq_o=1
- reg1_i  in  32  operand 1 / dividend
- reg2_i  in  32  operand 2 / divisor
- hi_i, lo_i  in  32 each  forwarded current HI/LO (mem > wb > regfile priority, resolved in EX)
- mulres_i  in  64  signed/unsigned-corrected product from EX
- hold_i  in  1  EX held by a downstream stall; freezes the final state
- flush_i  in  1  pipeline flush (exception)
- div_result_i  in  64  {remainder, quotient} from divider
- div_ready_i  in  1  divider result valid (DivResultReady)
- div_start_o  out  1  level start to divider
- div_annul_o  out  1  abort divider, one-cycle pulse
- div_signed_o  out  1  signed divide
- div_opdata1_o, div_opdata2_o  out  32 each  divider operands
- stallreq_o  out  1  stall request to ctrl
- whilo_o  out  1  HI/LO write enable
- hi_o, lo_o  out  32 each  HI/LO write data
- busy_o  out  1  FSM not IDLE

Behaviour:
- States: IDLE, ACC, DIV_WAIT, DIV_END.
- Reset: state=IDLE, acc_reg=0, res_reg=0.
  - All outputs 0: stallreq_o, whilo_o, hi_o, lo_o, div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o, busy_o.
  - Reset mid-operation drops the operation silently; no annul pulse is generated.
- IDLE:
  - MADD/MADDU/MSUB/MSUBU: register acc_reg = mulres_i (MADD*) or ~mulres_i+1 (MSUB*); stallreq_o=1; go ACC.
  - DIV/DIVU with reg2_i!=0: div_start_o=1, operands=reg1_i/reg2_i, div_signed_o=(DIV); stallreq_o=1; go DIV_WAIT.
  - DIV/DIVU with reg2_i==0: res_reg={reg1_i, DIV_ZERO_LO}; stallreq_o=1; go DIV_END. Divider is not started.
  - Other aluops: all outputs 0.
- ACC:
  - Combinational outputs: {hi_o,lo_o}={hi_i,lo_i}+acc_reg (mod 2^64), whilo_o=1, stallreq_o=0.
  - hold_i keeps ACC; otherwise go IDLE.
  - Total EX occupancy is 2 cycles.
- DIV_WAIT:
  - div_start_o=1 and operands held from registered copies; stallreq_o=1.
  - On div_ready_i: res_reg=div_result_i; go DIV_END. div_start_o drops in the next cycle.
- DIV_END:
  - whilo_o=1, {hi_o,lo_o}=res_reg, stallreq_o=0.
  - hold_i keeps DIV_END; otherwise go IDLE.
  - Latency: 1 start cycle + divider cycles + 1 end cycle.
- flush_i (highest priority, any state):
  - Next state IDLE; whilo_o=0 and stallreq_o=0 in the flush cycle.
  - If the state is DIV_WAIT, div_annul_o=1 in that cycle and div_start_o=0.
  - A new op in IDLE is not accepted in the flush cycle.
- Simultaneous div_ready_i and flush_i: flush wins; the result is discarded.
- A 64-bit accumulate carry out of bit 63 is discarded; no overflow trap.
- busy_o = (state != IDLE).

Decomposition:
- defines.v gains:
  - EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP (if absent).
  - MDS_IDLE/MDS_ACC/MDS_DIV_WAIT/MDS_DIV_END as 2-bit encodings.
  - Reuse DivStart, DivStop, DivResultReady, Stop, NoStop.
- No sub-module needed. The 64-bit adder stays inline.

Test Plan:
- MADD, hi_i:lo_i=0:5, mulres_i=64'd12 -> stallreq_o=1 for cycle 1; cycle 2 whilo_o=1, hi_o=0, lo_o=17, stallreq_o=0.
- MSUB, hi_i:lo_i=0:0, mulres_i=64'd1 -> cycle 2: hi_o=lo_o=32'hFFFFFFFF; ACC with hold_i=1 for 3 cycles -> outputs stable, state ACC until release.
- DIV, reg1=-7, reg2=2, divider ready after 33 cycles with {32'hFFFFFFFF, 32'hFFFFFFFD} -> div_signed_o=1, start high until ready; next cycle whilo_o=1, hi_o=FFFFFFFF, lo_o=FFFFFFFD.
- DIVU, reg2=0, reg1=9 -> div_start_o never asserted; 1 stall cycle, then hi_o=9, lo_o=FFFFFFFF.
- DIV in DIV_WAIT, flush_i at cycle 5 -> div_annul_o=1 for 1 cycle, whilo_o=0, IDLE next; a following MADDU is accepted the cycle after.
- Synchronous reset asserted in DIV_WAIT -> next cycle all outputs 0, busy_o=0, no annul pulse.
